// File: rtl/cond_exec_stage_pkg.sv
// Shared constants and types for the conditional-execute stage:
// condition codes, NZCV bit positions and the D->E control bundle.
package cond_exec_stage_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       pcsrc;
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       alusrc;
        logic [1:0] alucontrol;
        logic [1:0] flagwrite;
        logic [3:0] cond;
    } ctrl_t;

    // A bubble carries no side effects and an always-true condition.
    localparam ctrl_t CTRL_BUBBLE = '{
        pcsrc: 1'b0, regwrite: 1'b0, memtoreg: 1'b0, memwrite: 1'b0,
        branch: 1'b0, alusrc: 1'b0, alucontrol: 2'b00, flagwrite: 2'b00,
        cond: COND_AL
    };

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Combinational condition evaluator: decides whether an instruction with
// condition field Cond executes given the architectural NZCV flags.
module cond_check
    import cond_exec_stage_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v, ge;

    assign n  = Flags[FLAG_N];
    assign z  = Flags[FLAG_Z];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign ge = (n == v);

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~z & ge;
            COND_LE: CondEx = z | ~ge;
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage control: D->E pipeline register, NZCV flag register and
// condition gating of the side-effecting controls.
module cond_exec_stage
    import cond_exec_stage_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       PCSrcD,
    input  logic       RegWriteD,
    input  logic       MemtoRegD,
    input  logic       MemWriteD,
    input  logic       BranchD,
    input  logic       ALUSrcD,
    input  logic [1:0] ALUControlD,
    input  logic [1:0] FlagWriteD,
    input  logic [3:0] CondD,
    input  logic [3:0] ALUFlags,
    output logic       PCSrcEC,
    output logic       RegWriteEC,
    output logic       MemWriteEC,
    output logic       BranchTakenE,
    output logic       MemtoRegE,
    output logic       ALUSrcE,
    output logic [1:0] ALUControlE,
    output logic       CondExE,
    output logic [3:0] FlagsE
);

    ctrl_t      ctrl_q, ctrl_d;
    logic [3:0] flags_q, flags_d;
    logic       wr_nz, wr_cv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q  <= CTRL_BUBBLE;
            flags_q <= FLAGS_RST;
        end else begin
            ctrl_q  <= ctrl_d;
            flags_q <= flags_d;
        end
    end

    // Flush takes priority over stall so a bubble always enters E.
    always_comb begin
        ctrl_d = ctrl_q;
        if (FlushE) begin
            ctrl_d = CTRL_BUBBLE;
        end else if (!StallE) begin
            ctrl_d = '{
                pcsrc: PCSrcD, regwrite: RegWriteD, memtoreg: MemtoRegD,
                memwrite: MemWriteD, branch: BranchD, alusrc: ALUSrcD,
                alucontrol: ALUControlD, flagwrite: FlagWriteD, cond: CondD
            };
        end
    end

    cond_check u_cond_check (
        .Cond   (ctrl_q.cond),
        .Flags  (flags_q),
        .CondEx (CondExE)
    );

    // A stalled E instruction is re-presented next cycle, so it only
    // writes flags on the edge where it actually leaves E.
    assign wr_nz = ctrl_q.flagwrite[1] & CondExE & ~StallE;
    assign wr_cv = ctrl_q.flagwrite[0] & CondExE & ~StallE;

    always_comb begin
        flags_d = flags_q;
        if (wr_nz) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (wr_cv) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
    end

    assign PCSrcEC      = ctrl_q.pcsrc    & CondExE;
    assign RegWriteEC   = ctrl_q.regwrite & CondExE;
    assign MemWriteEC   = ctrl_q.memwrite & CondExE;
    assign BranchTakenE = ctrl_q.branch   & CondExE;
    assign MemtoRegE    = ctrl_q.memtoreg;
    assign ALUSrcE      = ctrl_q.alusrc;
    assign ALUControlE  = ctrl_q.alucontrol;
    assign FlagsE       = flags_q;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed bench for cond_exec_stage: flag update/visibility, gating,
// stall/flush interaction, async reset and a full condition-code sweep.
module tb_cond_exec_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       StallE, FlushE;
    logic       PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD;
    logic [1:0] ALUControlD, FlagWriteD;
    logic [3:0] CondD, ALUFlags;
    logic       PCSrcEC, RegWriteEC, MemWriteEC, BranchTakenE;
    logic       MemtoRegE, ALUSrcE, CondExE;
    logic [1:0] ALUControlE;
    logic [3:0] FlagsE;

    int compared   = 0;
    int mismatched = 0;

    cond_exec_stage #(.FLAGS_RST(4'b0000)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
        .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
        .ALUFlags(ALUFlags), .PCSrcEC(PCSrcEC), .RegWriteEC(RegWriteEC),
        .MemWriteEC(MemWriteEC), .BranchTakenE(BranchTakenE),
        .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .CondExE(CondExE), .FlagsE(FlagsE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pc, input logic rw, input logic m2r, input logic mw,
                         input logic br, input logic as, input logic [1:0] ac,
                         input logic [1:0] fw, input logic [3:0] cd);
        PCSrcD = pc; RegWriteD = rw; MemtoRegD = m2r; MemWriteD = mw;
        BranchD = br; ALUSrcD = as; ALUControlD = ac; FlagWriteD = fw; CondD = cd;
    endtask

    function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        reset = 1'b0; StallE = 1'b0; FlushE = 1'b0; ALUFlags = 4'b0000;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'hE);
        repeat (2) tick();
        check("rst_flags", FlagsE, 4'b0000);
        check("rst_gated", {PCSrcEC, RegWriteEC, MemWriteEC, BranchTakenE}, 4'b0000);
        check("rst_condex", {3'b000, CondExE}, 4'b0001);
        check("rst_ungated", {MemtoRegE, ALUSrcE, ALUControlE}, 4'b0000);
        reset = 1'b1;
        tick();
        check("post_rst_gated", {PCSrcEC, RegWriteEC, MemWriteEC, BranchTakenE}, 4'b0000);

        // SUBS sets Z; flags become visible to the following BEQ
        drive(0, 1, 0, 0, 0, 0, 2'b01, 2'b11, 4'hE);
        tick();
        ALUFlags = 4'b0100;
        drive(1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'h0);
        #1;
        check("subs_no_fwd", FlagsE, 4'b0000);
        tick();
        check("subs_flags", FlagsE, 4'b0100);
        check("beq_taken", {2'b00, BranchTakenE, PCSrcEC}, 4'b0011);

        // ADDNE fails with Z=1: no register write, no flag write
        drive(0, 1, 0, 0, 0, 0, 2'b00, 2'b11, 4'h1);
        tick();
        ALUFlags = 4'b1000;
        #1;
        check("addne_regwrite", {3'b000, RegWriteEC}, 4'b0000);
        check("addne_condex", {3'b000, CondExE}, 4'b0000);
        drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'hE);
        tick();
        check("addne_flags", FlagsE, 4'b0100);

        // Flush wins over stall
        drive(0, 0, 0, 1, 0, 0, 2'b00, 2'b11, 4'hE);
        FlushE = 1'b1; StallE = 1'b1; ALUFlags = 4'b1111;
        tick();
        check("flush_memwrite", {3'b000, MemWriteEC}, 4'b0000);
        check("flush_cond_al", {3'b000, CondExE}, 4'b0001);
        FlushE = 1'b0; StallE = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'hE);
        tick();
        check("flush_no_flagwr", FlagsE, 4'b0100);

        drive(0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 4'hE);
        tick();
        check("memwrite_al", {2'b00, MemWriteEC, MemtoRegE}, 4'b0011);

        // Stall holds a N,Z-writing instruction for three edges
        drive(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 4'hE);
        ALUFlags = 4'b1000;
        tick();
        StallE = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 4'hE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_flags", FlagsE, 4'b0100);
            check("stall_aluctl", {ALUSrcE, 1'b0, ALUControlE}, 4'b1010);
        end
        StallE = 1'b0;
        tick();
        check("unstall_flags", FlagsE, 4'b1000);
        check("unstall_aluctl", {2'b00, ALUControlE}, 4'b0001);
        drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'hE);
        tick();

        // Sweep every flag value against every condition code
        for (int f = 0; f < 16; f++) begin
            drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 4'hE);
            tick();
            ALUFlags = 4'(f);
            drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'hE);
            tick();
            check("sweep_flags", FlagsE, 4'(f));
            for (int c = 0; c < 16; c++) begin
                drive(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'(c));
                tick();
                check($sformatf("cond_%0h_flags_%0h", c, f), {2'b00, RegWriteEC, CondExE},
                      {2'b00, cond_model(4'(c), 4'(f)), cond_model(4'(c), 4'(f))});
            end
        end

        // C,V-only write
        drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'hE);
        tick();
        ALUFlags = 4'b0000;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'hE);
        tick();
        check("cv_only", FlagsE, 4'b1100);

        // Async reset mid-stream discards the E instruction
        drive(0, 1, 0, 0, 0, 0, 2'b00, 2'b11, 4'hE);
        tick();
        ALUFlags = 4'b0101;
        #1;
        check("pre_rst_regwrite", {3'b000, RegWriteEC}, 4'b0001);
        reset = 1'b0;
        #1;
        check("mid_rst_flags", FlagsE, 4'b0000);
        check("mid_rst_regwrite", {3'b000, RegWriteEC}, 4'b0000);
        drive(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'hE);
        reset = 1'b1;
        tick();
        check("post_mid_rst_flags", FlagsE, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
